mem_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between the processor's memory port
//  (P) and the program loader / IO master (L). Fixed priority to P, with a

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the processor port (P) and the loader port (L).
// P has fixed priority; L is forced through after STARVE_MAX consecutive losses.
module mem_arbiter #(
    parameter int WIDTH      = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_req,
    input  logic             p_we,
    input  logic [WIDTH-1:0] p_adr,
    input  logic [WIDTH-1:0] p_wdata,
    output logic             p_gnt,
    output logic [WIDTH-1:0] p_rdata,
    output logic             p_rvalid,
    input  logic             l_req,
    input  logic             l_we,
    input  logic [WIDTH-1:0] l_adr,
    input  logic [WIDTH-1:0] l_wdata,
    output logic             l_gnt,
    output logic [WIDTH-1:0] l_rdata,
    output logic             l_rvalid,
    output logic             mem_re,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam int            CW        = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);
    localparam logic [1:0]    LAT_INIT  = 2'(MEM_LAT);

    logic [1:0]       state;
    logic [CW-1:0]    starveCnt;
    logic [1:0]       latCnt;
    logic             ownerL;

    logic             anyReq;
    logic             lWins;
    logic             selWe;
    logic [WIDTH-1:0] selAdr;
    logic [WIDTH-1:0] selWdata;

    always_comb begin
        anyReq   = p_req | l_req;
        lWins    = l_req & (~p_req | (starveCnt == STARVE_TOP));
        selWe    = lWins ? l_we    : p_we;
        selAdr   = lWins ? l_adr   : p_adr;
        selWdata = lWins ? l_wdata : p_wdata;
    end

    // Strobes and grants are registered on the IDLE->ISSUE edge so they are
    // visible for exactly the ISSUE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            starveCnt <= '0;
            latCnt    <= '0;
            ownerL    <= 1'b0;
            p_gnt     <= 1'b0;
            p_rdata   <= '0;
            p_rvalid  <= 1'b0;
            l_gnt     <= 1'b0;
            l_rdata   <= '0;
            l_rvalid  <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
        end else begin
            p_gnt    <= 1'b0;
            l_gnt    <= 1'b0;
            p_rvalid <= 1'b0;
            l_rvalid <= 1'b0;
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        ownerL    <= lWins;
                        mem_adr   <= selAdr;
                        mem_wdata <= selWdata;
                        mem_re    <= ~selWe;
                        mem_we    <= selWe;
                        p_gnt     <= ~lWins;
                        l_gnt     <= lWins;
                        state     <= ISSUE;
                    end
                    if (!l_req || lWins) begin
                        starveCnt <= '0;
                    end else if (starveCnt != STARVE_TOP) begin
                        starveCnt <= starveCnt + 1'b1;
                    end
                end
                ISSUE: begin
                    latCnt <= LAT_INIT;
                    state  <= mem_we ? IDLE : WAIT;
                end
                WAIT: begin
                    latCnt <= latCnt - 1'b1;
                    if (latCnt == 2'd1) begin
                        if (ownerL) begin
                            l_rdata  <= mem_rdata;
                            l_rvalid <= 1'b1;
                        end else begin
                            p_rdata  <= mem_rdata;
                            p_rvalid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each with a
// behavioural memory; read data is scoreboarded against a shadow memory.
module tb_mem_arbiter;

    localparam int W = 16;

    typedef struct {
        int         inst;
        int         port;
        logic [W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic         req    [2][2];
    logic         we     [2][2];
    logic [W-1:0] adr    [2][2];
    logic [W-1:0] wdata  [2][2];
    logic         gnt    [2][2];
    logic [W-1:0] rdata  [2][2];
    logic         rvalid [2][2];
    logic         memRe    [2];
    logic         memWe    [2];
    logic [W-1:0] memAdr   [2];
    logic [W-1:0] memWdata [2];
    logic [W-1:0] memRdata [2];

    logic [W-1:0] shadow  [2][1024];
    logic [W-1:0] rdModel [2][2];
    int           lastGnt [2][2];
    exp_t         expQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.WIDTH(W), .MEM_LAT(1), .STARVE_MAX(4)) dutA (
        .clk(clk), .reset(reset),
        .p_req(req[0][0]), .p_we(we[0][0]), .p_adr(adr[0][0]), .p_wdata(wdata[0][0]),
        .p_gnt(gnt[0][0]), .p_rdata(rdata[0][0]), .p_rvalid(rvalid[0][0]),
        .l_req(req[0][1]), .l_we(we[0][1]), .l_adr(adr[0][1]), .l_wdata(wdata[0][1]),
        .l_gnt(gnt[0][1]), .l_rdata(rdata[0][1]), .l_rvalid(rvalid[0][1]),
        .mem_re(memRe[0]), .mem_we(memWe[0]), .mem_adr(memAdr[0]),
        .mem_wdata(memWdata[0]), .mem_rdata(memRdata[0])
    );

    mem_arbiter #(.WIDTH(W), .MEM_LAT(3), .STARVE_MAX(4)) dutB (
        .clk(clk), .reset(reset),
        .p_req(req[1][0]), .p_we(we[1][0]), .p_adr(adr[1][0]), .p_wdata(wdata[1][0]),
        .p_gnt(gnt[1][0]), .p_rdata(rdata[1][0]), .p_rvalid(rvalid[1][0]),
        .l_req(req[1][1]), .l_we(we[1][1]), .l_adr(adr[1][1]), .l_wdata(wdata[1][1]),
        .l_gnt(gnt[1][1]), .l_rdata(rdata[1][1]), .l_rvalid(rvalid[1][1]),
        .mem_re(memRe[1]), .mem_we(memWe[1]), .mem_adr(memAdr[1]),
        .mem_wdata(memWdata[1]), .mem_rdata(memRdata[1])
    );

    for (genvar g = 0; g < 2; g++) begin : gMem
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [W-1:0] mem  [1024];
        logic [W-1:0] pipe [LAT];
        always @(posedge clk) begin
            if (memWe[g]) mem[memAdr[g][9:0]] <= memWdata[g];
            pipe[0] <= mem[memAdr[g][9:0]];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign memRdata[g] = pipe[LAT-1];
    end

    function automatic int latOf(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic checkAllZero(input string tag);
        for (int d = 0; d < 2; d++) begin
            logic [9:0] v;
            v = {gnt[d][0], gnt[d][1], rvalid[d][0], rvalid[d][1], memRe[d], memWe[d],
                 |memAdr[d], |memWdata[d], |rdata[d][0], |rdata[d][1]};
            checkEq(tag, 32'(v), 0);
        end
    endtask

    // Holds the request until its grant, then checks the memory-side command.
    task automatic access(input int d, input int p, input logic w, input logic [W-1:0] a,
                          input logic [W-1:0] wd, output int gntCyc);
        exp_t e;
        we[d][p] = w;
        adr[d][p] = a;
        wdata[d][p] = wd;
        req[d][p] = 1'b1;
        if (!w) begin
            e.inst = d;
            e.port = p;
            e.data = shadow[d][a[9:0]];
            expQ.push_back(e);
        end
        gntCyc = -1;
        for (int n = 0; n < 60 && gntCyc < 0; n++) begin
            @(negedge clk);
            if (gnt[d][p]) gntCyc = cyc;
        end
        req[d][p] = 1'b0;
        if (gntCyc < 0) begin
            checkEq("gnt_timeout", 32'(gnt[d][p]), 1);
        end else begin
            lastGnt[d][p] = gntCyc;
            checkEq("mem_re", 32'(memRe[d]), 32'(!w));
            checkEq("mem_we", 32'(memWe[d]), 32'(w));
            checkEq("mem_adr", 32'(memAdr[d]), 32'(a));
            checkEq("gnt_other", 32'(gnt[d][1-p]), 0);
            if (w) begin
                checkEq("mem_wdata", 32'(memWdata[d]), 32'(wd));
                shadow[d][a[9:0]] = wd;
            end
        end
    endtask

    task automatic waitDone();
        for (int i = 0; i < 40 && expQ.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checkEq("rvalid_timeout", 32'(expQ.size()), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (memRe[d] || memWe[d]) begin
                checkEq("strobe_excl", 32'(memRe[d] & memWe[d]), 0);
                checkEq("strobe_in_issue", 32'(gnt[d][0] | gnt[d][1]), 1);
            end
            for (int p = 0; p < 2; p++) begin
                if (rvalid[d][p]) begin
                    if (expQ.size() == 0) begin
                        checkEq("spurious_rvalid", 32'(rvalid[d][p]), 0);
                    end else begin
                        e = expQ.pop_front();
                        checkEq("rvalid_owner", 32'(d * 2 + p), 32'(e.inst * 2 + e.port));
                        checkEq("rdata", 32'(rdata[d][p]), 32'(e.data));
                        checkEq("rvalid_latency", 32'(cyc - lastGnt[d][p]), 32'(1 + latOf(d)));
                        rdModel[d][p] = e.data;
                        checkEq("other_rdata", 32'(rdata[d][1-p]), 32'(rdModel[d][1-p]));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, g0, g1, gl1, gl2, gp;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0;
                we[d][p] = 1'b0;
                adr[d][p] = '0;
                wdata[d][p] = '0;
                rdModel[d][p] = '0;
                lastGnt[d][p] = 0;
            end
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset_outputs");
        reset = 1'b1;
        @(negedge clk);

        // P read with MEM_LAT=1 after L preloads the location.
        access(0, 1, 1'b1, 16'h0010, 16'h1234, g0);
        @(negedge clk);
        t0 = cyc;
        access(0, 0, 1'b0, 16'h0010, 16'h0000, g0);
        checkEq("p_read_gnt_lat", 32'(g0 - t0), 1);
        waitDone();
        checkEq("p_rdata_hold", 32'(rdata[0][0]), 32'h1234);

        // Simultaneous writes: P first, L two cycles later.
        t0 = cyc;
        fork
            access(0, 0, 1'b1, 16'h0100, 16'h00AA, g0);
            access(0, 1, 1'b1, 16'h0101, 16'h00BB, g1);
        join
        checkEq("both_p_gnt", 32'(g0 - t0), 1);
        checkEq("both_l_gnt", 32'(g1 - t0), 3);
        @(negedge clk);
        checkEq("mem_0100", 32'(gMem[0].mem[10'h100]), 32'h00AA);
        checkEq("mem_0101", 32'(gMem[0].mem[10'h101]), 32'h00BB);
        access(0, 0, 1'b0, 16'h0101, 16'h0000, g0);
        waitDone();
        access(0, 1, 1'b0, 16'h0100, 16'h0000, g1);
        waitDone();
        checkEq("l_rdata_0100", 32'(rdata[0][1]), 32'h00AA);

        // Starvation: L forced on its 5th arbitration, then counter restarts.
        t0 = cyc;
        fork
            begin
                for (int k = 0; k < 9; k++) access(0, 0, 1'b1, 16'h0300 + 16'(k), 16'(k), gp);
            end
            begin
                access(0, 1, 1'b1, 16'h0310, 16'h0C01, gl1);
                access(0, 1, 1'b1, 16'h0311, 16'h0C02, gl2);
            end
        join
        checkEq("starve_first_l_gnt", 32'(gl1 - t0), 9);
        checkEq("starve_second_l_gnt", 32'(gl2 - t0), 19);
        checkEq("starve_last_p_gnt", 32'(gp - t0), 21);

        // L write then P read of the same word; L's rdata must stay put.
        @(negedge clk);
        access(0, 1, 1'b1, 16'h0200, 16'hBEEF, g1);
        @(negedge clk);
        access(0, 0, 1'b0, 16'h0200, 16'h0000, g0);
        waitDone();
        checkEq("p_rdata_beef", 32'(rdata[0][0]), 32'hBEEF);
        checkEq("l_rdata_untouched", 32'(rdata[0][1]), 32'h00AA);

        // MEM_LAT=3 read by L; P arriving during ISSUE waits for WAIT to end.
        access(1, 0, 1'b1, 16'h0040, 16'h5A5A, g0);
        @(negedge clk);
        t0 = cyc;
        fork
            access(1, 1, 1'b0, 16'h0040, 16'h0000, gl1);
            begin
                @(negedge clk);
                access(1, 0, 1'b1, 16'h0041, 16'h0001, gp);
            end
        join
        checkEq("lat3_l_gnt", 32'(gl1 - t0), 1);
        checkEq("lat3_p_blocked", 32'(gp - t0), 6);
        checkEq("lat3_l_rdata", 32'(rdata[1][1]), 32'h5A5A);

        // Reset asserted while a read is in WAIT.
        access(1, 0, 1'b0, 16'h0040, 16'h0000, g0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 checkAllZero("async_reset");
        expQ.delete();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) rdModel[d][p] = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        checkEq("rdata_after_reset", 32'(rdata[1][0]), 0);
        t0 = cyc;
        access(1, 1, 1'b1, 16'h0050, 16'h0777, g1);
        checkEq("idle_after_reset", 32'(g1 - t0), 1);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
